// File: rtl/counter_pkg.sv
`default_nettype none
// counter_pkg: shared direction encoding and modulo next-count helper for counter primitives.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  localparam int C_MAX_WIDTH = 32;

  // Wrapped successor/predecessor of q within 0..modulus-1, at C_MAX_WIDTH bits.
  function automatic logic [C_MAX_WIDTH-1:0] next_count(
    input logic [C_MAX_WIDTH-1:0] q,
    input count_dir_e             up,
    input logic [C_MAX_WIDTH-1:0] modulus
  );
    logic [C_MAX_WIDTH-1:0] r;
    if (up == DIR_UP) begin
      r = (q == modulus - 1) ? '0 : q + 1;
    end else begin
      r = (q == '0) ? modulus - 1 : q - 1;
    end
    return r;
  endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/posedge_nbit_updown_counter.sv
`default_nettype none
// posedge_nbit_updown_counter: WIDTH-bit modulo up/down counter with preset, load and TC/WRAP flags.
// Macro COUNTER_SATURATE_EN: saturate at 0 / MODULUS-1 instead of wrapping (WRAP tied 0).
module posedge_nbit_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PRE,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0]       C_MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [C_MAX_WIDTH-1:0] C_MOD_EXT = C_MAX_WIDTH'(MODULUS);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] step_val;
  logic             at_limit;
  count_dir_e       dir;

  assign dir      = count_dir_e'(UP);
  assign at_limit = (dir == DIR_UP) ? (q_q == C_MAX_Q) : (q_q == '0);
  assign step_val = WIDTH'(next_count(C_MAX_WIDTH'(q_q), dir, C_MOD_EXT));
  assign TC       = EN & at_limit;
  assign Q        = q_q;

`ifdef COUNTER_SATURATE_EN

  always_comb begin
    q_d = q_q;
    if (PRE) begin
      q_d = C_MAX_Q;
    end else if (LOAD) begin
      q_d = (C_MAX_WIDTH'(D) >= C_MOD_EXT) ? C_MAX_Q : D;
    end else if (EN && !at_limit) begin
      q_d = step_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign WRAP = 1'b0;

`else

  logic wrap_q;
  logic wrap_d;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (PRE) begin
      q_d = C_MAX_Q;
    end else if (LOAD) begin
      // Out-of-range load values clamp so no illegal state is ever held.
      q_d = (C_MAX_WIDTH'(D) >= C_MOD_EXT) ? C_MAX_Q : D;
    end else if (EN) begin
      q_d    = step_val;
      wrap_d = at_limit;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign WRAP = wrap_q;

`endif

endmodule : posedge_nbit_updown_counter
`default_nettype wire

// File: tb/tb_posedge_nbit_updown_counter.sv
`default_nettype none
// Directed bench: one MODULUS=8 and one MODULUS=6 instance share stimulus.
module tb_posedge_nbit_updown_counter;

  logic       clk = 1'b0;
  logic       rst, pre, en, up, load;
  logic [2:0] d;
  logic [2:0] q8, q6;
  logic       tc8, tc6, wrap8, wrap6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  posedge_nbit_updown_counter #(.WIDTH(3), .MODULUS(8)) u_m8 (
    .CLK(clk), .RST(rst), .PRE(pre), .EN(en), .UP(up), .LOAD(load), .D(d),
    .Q(q8), .TC(tc8), .WRAP(wrap8)
  );

  posedge_nbit_updown_counter #(.WIDTH(3), .MODULUS(6)) u_m6 (
    .CLK(clk), .RST(rst), .PRE(pre), .EN(en), .UP(up), .LOAD(load), .D(d),
    .Q(q6), .TC(tc6), .WRAP(wrap6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

`ifdef COUNTER_SATURATE_EN
  int q1[10] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
  int w1[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int q2[7]  = '{4, 3, 2, 1, 0, 0, 0};
  int w2[7]  = '{0, 0, 0, 0, 0, 0, 0};
  int q6u[4] = '{7, 7, 7, 7};
  int w6u[4] = '{0, 0, 0, 0};
  int q6d[2] = '{0, 0};
  int w6d[2] = '{0, 0};
  int q5w8 = 7, q5w6 = 5, w5 = 0;
`else
  int q1[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
  int w1[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int q2[7]  = '{4, 3, 2, 1, 0, 5, 4};
  int w2[7]  = '{0, 0, 0, 0, 0, 1, 0};
  int q6u[4] = '{7, 0, 1, 2};
  int w6u[4] = '{0, 1, 0, 0};
  int q6d[2] = '{0, 7};
  int w6d[2] = '{0, 1};
  int q5w8 = 0, q5w6 = 0, w5 = 1;
`endif

  initial begin
    rst = 1'b1; pre = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = 3'd0;

    // Reset
    tick();
    check("rst_q8", q8, 0);
    check("rst_q6", q6, 0);
    check("rst_wrap8", wrap8, 0);
    check("rst_tc8_en0", tc8, 0);

    // Count up through the MODULUS=8 terminal
    rst = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    check("up_tc8_at0", tc8, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("up_q8[%0d]", i), q8, q1[i]);
      check($sformatf("up_wrap8[%0d]", i), wrap8, w1[i]);
      check($sformatf("up_tc8[%0d]", i), tc8, (q1[i] == 7) ? 1 : 0);
    end

    // Preset, then count down through the MODULUS=6 terminal
    en = 1'b0; pre = 1'b1;
    tick();
    check("pre_q6", q6, 5);
    check("pre_q8", q8, 7);
    check("pre_wrap6", wrap6, 0);
    pre = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("dn_q6[%0d]", i), q6, q2[i]);
      check($sformatf("dn_wrap6[%0d]", i), wrap6, w2[i]);
      check($sformatf("dn_tc6[%0d]", i), tc6, (q2[i] == 0) ? 1 : 0);
    end
    check("dn_q8_end", q8, 0);
    check("dn_tc8_at0", tc8, 1);

    // Parallel load, clamp, and load beating a terminal count
    en = 1'b0; load = 1'b1; d = 3'd3;
    tick();
    check("ld3_q6", q6, 3);
    check("ld3_q8", q8, 3);
    d = 3'd7;
    tick();
    check("ld7_clamp_q6", q6, 5);
    check("ld7_q8", q8, 7);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    check("tc6_before_ld", tc6, 1);
    load = 1'b1; d = 3'd2;
    tick();
    check("ld2en_q6", q6, 2);
    check("ld2en_wrap6", wrap6, 0);
    check("ld2en_q8", q8, 2);
    check("ld2en_wrap8", wrap8, 0);

    // Hold with EN=0, then reverse direction
    load = 1'b0;
    tick();
    check("hold_pre_q6_a", q6, 3);
    tick();
    check("hold_pre_q6_b", q6, 4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_q6[%0d]", i), q6, 4);
      check($sformatf("hold_tc6[%0d]", i), tc6, 0);
    end
    en = 1'b1; up = 1'b0;
    tick();
    check("rev_q6_a", q6, 3);
    tick();
    check("rev_q6_b", q6, 2);

    // RST beats PRE; live TC; wrap pulse; reset clears WRAP
    en = 1'b0; pre = 1'b1;
    tick();
    check("pre2_q6", q6, 5);
    en = 1'b1; rst = 1'b1;
    tick();
    check("rstpre_q6", q6, 0);
    check("rstpre_q8", q8, 0);
    check("rstpre_wrap6", wrap6, 0);
    rst = 1'b0;
    tick();
    check("pre3_q6", q6, 5);
    check("pre3_q8", q8, 7);
    pre = 1'b0; up = 1'b1;
    #1;
    check("live_tc6_up", tc6, 1);
    up = 1'b0;
    #1;
    check("live_tc6_dn", tc6, 0);
    up = 1'b1; en = 1'b0;
    #1;
    check("live_tc6_en0", tc6, 0);
    en = 1'b1;
    tick();
    check("wrap_q6", q6, q5w6);
    check("wrap_q8", q8, q5w8);
    check("wrap_wrap6", wrap6, w5);
    check("wrap_wrap8", wrap8, w5);
    rst = 1'b1;
    tick();
    check("rstmid_q6", q6, 0);
    check("rstmid_wrap6", wrap6, 0);
    check("rstmid_wrap8", wrap8, 0);
    rst = 1'b0;

    // Upper and lower limits of MODULUS=8
    en = 1'b0; load = 1'b1; d = 3'd6;
    tick();
    check("ld6_q8", q8, 6);
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("lim_up_q8[%0d]", i), q8, q6u[i]);
      check($sformatf("lim_up_wrap8[%0d]", i), wrap8, w6u[i]);
      check($sformatf("lim_up_tc8[%0d]", i), tc8, (q6u[i] == 7) ? 1 : 0);
    end
    en = 1'b0; load = 1'b1; d = 3'd1;
    tick();
    check("ld1_q8", q8, 1);
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("lim_dn_q8[%0d]", i), q8, q6d[i]);
      check($sformatf("lim_dn_wrap8[%0d]", i), wrap8, w6d[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_posedge_nbit_updown_counter
`default_nettype wire
